rt_ibex_pcs_ctrl: RTL and testbench

Sequencing controller for the hardware preemptible context stack (PCS) in the register file. It decides when an incoming interrupt preempts the running context, tracks nesting depth and the active interrupt level, and issues the store (irq_ack) and restore (irq_exit) pulses to the PCS-equipped register file. It stalls the core pipeline while a context transfer is in flight and waits for the register file's restore-done handshake. It sits between the interrupt controller / ID-stage controller and the register file.

---
 rtl/rt_ibex_pcs_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rt_ibex_pcs_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_ibex_pcs_ctrl.sv
// rt_ibex_pcs_ctrl: sequencing controller for the preemptible context stack.
// Decides when a pending interrupt preempts the running context, tracks the
// nesting depth and active level, issues store/restore pulses to the register
// file, and stalls the pipeline while a context transfer is in flight.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   irq_valid_i/level_i    pending interrupt and its level
//   irq_take_i             core enters the handler this cycle
//   mret_i                 mret retiring this cycle
//   restore_done_i         register file restore-complete pulse
//   preempt_o              pending irq may preempt (combinational)
//   irq_ack_o / irq_exit_o store / restore pulses
//   stall_o                hold pipeline
//   level_o / depth_o      active level / nesting depth
//   full_o                 depth at capacity (combinational)
//   overflow_o/timeout_o   sticky error flags
`timescale 1ns/1ps

module rt_ibex_pcs_ctrl #(
   parameter int unsigned IrqLevelWidth  = 8,
   parameter int unsigned MaxDepth       = 4,
   parameter int unsigned StoreCycles    = 1,
   parameter int unsigned RestoreTimeout = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            irq_valid_i,
   input  logic [IrqLevelWidth-1:0]        irq_level_i,
   input  logic                            irq_take_i,
   input  logic                            mret_i,
   input  logic                            restore_done_i,
   output logic                            preempt_o,
   output logic                            irq_ack_o,
   output logic                            irq_exit_o,
   output logic                            stall_o,
   output logic [IrqLevelWidth-1:0]        level_o,
   output logic [$clog2(MaxDepth+1)-1:0]   depth_o,
   output logic                            full_o,
   output logic                            overflow_o,
   output logic                            timeout_o
);

   localparam int unsigned DepthW     = $clog2(MaxDepth + 1);
   localparam int unsigned IdxW       = (MaxDepth > 1) ? $clog2(MaxDepth) : 1;
   localparam int unsigned StackDepth = 2 ** IdxW;
   localparam int unsigned CntMax     = (StoreCycles > RestoreTimeout) ? StoreCycles
                                                                       : RestoreTimeout;
   localparam int unsigned CntW       = $clog2(CntMax + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] STORE   = 2'd1;
   localparam logic [1:0] RESTORE = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic [IrqLevelWidth-1:0] level_d;
   logic [DepthW-1:0]        depth_d;
   logic                     ack_d, exit_d, stall_d, overflow_d, timeout_d;
   logic                     push;
   logic [IrqLevelWidth-1:0] stack_q [StackDepth];
   logic [IdxW-1:0]          push_idx, pop_idx;

   // Capacity and preemption decisions, visible to the core in the same cycle.
   assign full_o    = (depth_o == DepthW'(MaxDepth));
   assign preempt_o = (state_q == IDLE) && irq_valid_i && (irq_level_i > level_o) && !full_o;

   assign push_idx = IdxW'(depth_o);
   assign pop_idx  = IdxW'(depth_o - DepthW'(1));

   // State and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         level_o    <= '0;
         depth_o    <= '0;
         irq_ack_o  <= 1'b0;
         irq_exit_o <= 1'b0;
         stall_o    <= 1'b0;
         overflow_o <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         level_o    <= level_d;
         depth_o    <= depth_d;
         irq_ack_o  <= ack_d;
         irq_exit_o <= exit_d;
         stall_o    <= stall_d;
         overflow_o <= overflow_d;
         timeout_o  <= timeout_d;
      end
   end

   // Level stack: saves the preempted level at the current depth on a push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(StackDepth); i++) begin
            stack_q[i] <= '0;
         end
      end else if (push) begin
         stack_q[push_idx] <= level_o;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_o;
      depth_d    = depth_o;
      ack_d      = 1'b0;
      exit_d     = 1'b0;
      stall_d    = stall_o;
      overflow_d = overflow_o;
      timeout_d  = timeout_o;
      push       = 1'b0;

      case (state_q)
         IDLE: begin
            stall_d = 1'b0;
            // mret outranks take; a thread-mode mret simply passes through.
            if (mret_i && (depth_o != '0)) begin
               exit_d  = 1'b1;
               stall_d = 1'b1;
               cnt_d   = '0;
               state_d = RESTORE;
            end else if (!mret_i && irq_take_i) begin
               if (full_o) begin
                  overflow_d = 1'b1;
               end else if (preempt_o) begin
                  push    = 1'b1;
                  level_d = irq_level_i;
                  depth_d = depth_o + DepthW'(1);
                  ack_d   = 1'b1;
                  stall_d = 1'b1;
                  cnt_d   = '0;
                  state_d = STORE;
               end
            end
         end

         // Stall counted from the ack cycle; inputs ignored.
         STORE: begin
            if (cnt_q == CntW'(StoreCycles - 1)) begin
               stall_d = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         // Pop on the handshake, or force it once the wait budget runs out.
         RESTORE: begin
            if (restore_done_i || (cnt_q == CntW'(RestoreTimeout - 1))) begin
               level_d = stack_q[pop_idx];
               depth_d = depth_o - DepthW'(1);
               stall_d = 1'b0;
               state_d = IDLE;
               if (!restore_done_i) begin
                  timeout_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            stall_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// Directed testbench for rt_ibex_pcs_ctrl with default parameters.
`timescale 1ns/1ps

module tb_rt_ibex_pcs_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       irq_valid_i;
   logic [7:0] irq_level_i;
   logic       irq_take_i;
   logic       mret_i;
   logic       restore_done_i;
   logic       preempt_o;
   logic       irq_ack_o;
   logic       irq_exit_o;
   logic       stall_o;
   logic [7:0] level_o;
   logic [2:0] depth_o;
   logic       full_o;
   logic       overflow_o;
   logic       timeout_o;

   int checks = 0;
   int errors = 0;

   rt_ibex_pcs_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .irq_valid_i    (irq_valid_i),
      .irq_level_i    (irq_level_i),
      .irq_take_i     (irq_take_i),
      .mret_i         (mret_i),
      .restore_done_i (restore_done_i),
      .preempt_o      (preempt_o),
      .irq_ack_o      (irq_ack_o),
      .irq_exit_o     (irq_exit_o),
      .stall_o        (stall_o),
      .level_o        (level_o),
      .depth_o        (depth_o),
      .full_o         (full_o),
      .overflow_o     (overflow_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      irq_valid_i    = 1'b0;
      irq_level_i    = 8'd0;
      irq_take_i     = 1'b0;
      mret_i         = 1'b0;
      restore_done_i = 1'b0;
      rst_ni         = 1'b0;
      #12;
      rst_ni = 1'b1;
      tick();
   endtask

   // Take an interrupt at the given level and let the store stall finish.
   task automatic take_level(input logic [7:0] lvl);
      irq_valid_i = 1'b1;
      irq_level_i = lvl;
      irq_take_i  = 1'b1;
      tick();
      irq_take_i  = 1'b0;
      irq_valid_i = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({irq_ack_o, irq_exit_o, stall_o, full_o, overflow_o, timeout_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000",
                  {irq_ack_o, irq_exit_o, stall_o, full_o, overflow_o, timeout_o});
      end
      checks++;
      if (level_o !== 8'd0 || depth_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got level %0d depth %0d want 0 0", level_o, depth_o);
      end
   endtask

   task automatic test_store();
      irq_valid_i = 1'b1;
      irq_level_i = 8'd3;
      #1;
      checks++;
      if (preempt_o !== 1'b1) begin
         errors++;
         $display("FAIL preempt_l3 got %b want 1", preempt_o);
      end
      irq_take_i = 1'b1;
      tick();
      irq_take_i  = 1'b0;
      irq_valid_i = 1'b0;
      checks++;
      if (irq_ack_o !== 1'b1 || stall_o !== 1'b1 || level_o !== 8'd3 || depth_o !== 3'd1) begin
         errors++;
         $display("FAIL store_n1 got ack %b stall %b level %0d depth %0d want 1 1 3 1",
                  irq_ack_o, stall_o, level_o, depth_o);
      end
      tick();
      checks++;
      if (irq_ack_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL store_n2 got ack %b stall %b want 0 0", irq_ack_o, stall_o);
      end
   endtask

   task automatic test_nesting();
      irq_valid_i = 1'b1;
      irq_level_i = 8'd2;
      #1;
      checks++;
      if (preempt_o !== 1'b0) begin
         errors++;
         $display("FAIL preempt_low got %b want 0", preempt_o);
      end
      irq_take_i = 1'b1;
      tick();
      irq_take_i = 1'b0;
      checks++;
      if (irq_ack_o !== 1'b0 || depth_o !== 3'd1 || level_o !== 8'd3 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL low_take got ack %b depth %0d level %0d ovf %b want 0 1 3 0",
                  irq_ack_o, depth_o, level_o, overflow_o);
      end
      irq_level_i = 8'd5;
      irq_take_i  = 1'b1;
      tick();
      irq_take_i  = 1'b0;
      irq_valid_i = 1'b0;
      checks++;
      if (irq_ack_o !== 1'b1 || depth_o !== 3'd2 || level_o !== 8'd5) begin
         errors++;
         $display("FAIL nest got ack %b depth %0d level %0d want 1 2 5",
                  irq_ack_o, depth_o, level_o);
      end
      tick();
   endtask

   task automatic test_restore();
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks++;
      if (irq_exit_o !== 1'b1 || stall_o !== 1'b1 || depth_o !== 3'd2) begin
         errors++;
         $display("FAIL exit_n1 got exit %b stall %b depth %0d want 1 1 2",
                  irq_exit_o, stall_o, depth_o);
      end
      tick();
      checks++;
      if (irq_exit_o !== 1'b0 || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL exit_n2 got exit %b stall %b want 0 1", irq_exit_o, stall_o);
      end
      tick();
      restore_done_i = 1'b1;
      tick();
      restore_done_i = 1'b0;
      checks++;
      if (level_o !== 8'd3 || depth_o !== 3'd1 || stall_o !== 1'b0 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL pop1 got level %0d depth %0d stall %b to %b want 3 1 0 0",
                  level_o, depth_o, stall_o, timeout_o);
      end
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      restore_done_i = 1'b1;
      tick();
      restore_done_i = 1'b0;
      checks++;
      if (level_o !== 8'd0 || depth_o !== 3'd0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL pop2 got level %0d depth %0d stall %b want 0 0 0",
                  level_o, depth_o, stall_o);
      end
      // Stray handshake while idle is ignored.
      restore_done_i = 1'b1;
      tick();
      restore_done_i = 1'b0;
      checks++;
      if (depth_o !== 3'd0 || stall_o !== 1'b0 || irq_exit_o !== 1'b0) begin
         errors++;
         $display("FAIL stray_done got depth %0d stall %b exit %b want 0 0 0",
                  depth_o, stall_o, irq_exit_o);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      take_level(8'd1);
      take_level(8'd2);
      take_level(8'd3);
      take_level(8'd4);
      checks++;
      if (full_o !== 1'b1 || depth_o !== 3'd4 || level_o !== 8'd4) begin
         errors++;
         $display("FAIL fill got full %b depth %0d level %0d want 1 4 4", full_o, depth_o, level_o);
      end
      irq_valid_i = 1'b1;
      irq_level_i = 8'd9;
      #1;
      checks++;
      if (preempt_o !== 1'b0) begin
         errors++;
         $display("FAIL preempt_full got %b want 0", preempt_o);
      end
      irq_take_i = 1'b1;
      tick();
      irq_take_i  = 1'b0;
      irq_valid_i = 1'b0;
      checks++;
      if (irq_ack_o !== 1'b0 || overflow_o !== 1'b1 || depth_o !== 3'd4 || level_o !== 8'd4) begin
         errors++;
         $display("FAIL overflow got ack %b ovf %b depth %0d level %0d want 0 1 4 4",
                  irq_ack_o, overflow_o, depth_o, level_o);
      end
      tick();
      tick();
      checks++;
      if (overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky got %b want 1", overflow_o);
      end
      // Pop from full: the level below the top is restored.
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      restore_done_i = 1'b1;
      tick();
      restore_done_i = 1'b0;
      checks++;
      if (level_o !== 8'd3 || depth_o !== 3'd3 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL pop_full got level %0d depth %0d full %b want 3 3 0",
                  level_o, depth_o, full_o);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      take_level(8'd3);
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
      end
      checks++;
      if (depth_o !== 3'd1 || timeout_o !== 1'b0 || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL to_early got depth %0d to %b stall %b want 1 0 1",
                  depth_o, timeout_o, stall_o);
      end
      tick();
      checks++;
      if (depth_o !== 3'd0 || level_o !== 8'd0 || timeout_o !== 1'b1 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL to_pop got depth %0d level %0d to %b stall %b want 0 0 1 0",
                  depth_o, level_o, timeout_o, stall_o);
      end
      tick();
      checks++;
      if (timeout_o !== 1'b1) begin
         errors++;
         $display("FAIL to_sticky got %b want 1", timeout_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      take_level(8'd3);
      mret_i      = 1'b1;
      irq_take_i  = 1'b1;
      irq_valid_i = 1'b1;
      irq_level_i = 8'd5;
      tick();
      mret_i      = 1'b0;
      irq_take_i  = 1'b0;
      irq_valid_i = 1'b0;
      checks++;
      if (irq_exit_o !== 1'b1 || irq_ack_o !== 1'b0 || depth_o !== 3'd1 || level_o !== 8'd3) begin
         errors++;
         $display("FAIL mret_take got exit %b ack %b depth %0d level %0d want 1 0 1 3",
                  irq_exit_o, irq_ack_o, depth_o, level_o);
      end
      restore_done_i = 1'b1;
      tick();
      restore_done_i = 1'b0;
      checks++;
      if (depth_o !== 3'd0 || level_o !== 8'd0) begin
         errors++;
         $display("FAIL mret_take_pop got depth %0d level %0d want 0 0", depth_o, level_o);
      end
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks++;
      if (irq_exit_o !== 1'b0 || stall_o !== 1'b0 || depth_o !== 3'd0) begin
         errors++;
         $display("FAIL thread_mret got exit %b stall %b depth %0d want 0 0 0",
                  irq_exit_o, stall_o, depth_o);
      end
   endtask

   task automatic test_reset_mid();
      take_level(8'd6);
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks++;
      if (stall_o !== 1'b1 || level_o !== 8'd6) begin
         errors++;
         $display("FAIL pre_rst got stall %b level %0d want 1 6", stall_o, level_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({irq_ack_o, irq_exit_o, stall_o, full_o, overflow_o, timeout_o} !== 6'b0 ||
          level_o !== 8'd0 || depth_o !== 3'd0) begin
         errors++;
         $display("FAIL async_rst got flags %b level %0d depth %0d want 000000 0 0",
                  {irq_ack_o, irq_exit_o, stall_o, full_o, overflow_o, timeout_o},
                  level_o, depth_o);
      end
      #10;
      rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_store();
      test_nesting();
      test_restore();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
